mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one word memory port, one transaction in flight.
// Grant and o_mem_req appear the cycle after the selecting edge; responses are combinational on i_mem_rvalid.
package rapid_pkg;
  parameter int XLEN = 32;
endpackage

module mem_port_arbiter #(
  parameter int XLEN = rapid_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [2:0]      i_dm_size,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wdata,
  output logic            o_dm_gnt,
  output logic            o_dm_rvalid,
  output logic            o_dm_err,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  state_t          state_q;
  logic            last_dm_q;
  logic            own_dm_q;
  logic            store_q;
  logic [1:0]      lane_q;
  logic [2:0]      size_q;
  logic            if_gnt_q;
  logic            dm_gnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_be_q;

  logic            pick_dm_d;
  logic            dm_bad_d;
  logic            mem_we_d;
  logic [XLEN-1:0] mem_addr_d;
  logic [XLEN-1:0] mem_wdata_d;
  logic [3:0]      mem_be_d;
  logic [1:0]      dm_lane;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_val;
  logic            dm_rsp;
  logic            err_rsp;

  assign dm_lane   = i_dm_addr[1:0];
  // On a tie the requester that did not win last time takes the port.
  assign pick_dm_d = i_dm_req && (!i_if_req || !last_dm_q);

  always_comb begin
    dm_bad_d = 1'b0;
    case (i_dm_size)
      3'b000:  dm_bad_d = 1'b0;
      3'b001:  dm_bad_d = dm_lane[0];
      3'b010:  dm_bad_d = |dm_lane;
      3'b100:  dm_bad_d = i_dm_we;
      3'b101:  dm_bad_d = i_dm_we | dm_lane[0];
      default: dm_bad_d = 1'b1;
    endcase
  end

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = i_if_addr & ~XLEN'(3);
    mem_wdata_d = '0;
    mem_be_d    = 4'b1111;
    if (pick_dm_d) begin
      mem_we_d   = i_dm_we;
      mem_addr_d = i_dm_addr & ~XLEN'(3);
      if (i_dm_we) begin
        case (i_dm_size[1:0])
          2'b00: begin
            mem_be_d    = 4'b0001 << dm_lane;
            mem_wdata_d = XLEN'(i_dm_wdata[7:0]) << {dm_lane, 3'b000};
          end
          2'b01: begin
            mem_be_d    = 4'b0011 << dm_lane;
            mem_wdata_d = XLEN'(i_dm_wdata[15:0]) << {dm_lane, 3'b000};
          end
          default: mem_wdata_d = i_dm_wdata;
        endcase
      end
    end
  end

  assign rd_shift = i_mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      3'b000:  load_val = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // ERR holds two cycles: the grant pulse, then the error response.
  assign err_rsp     = (state_q == S_ERR) && !dm_gnt_q;
  assign dm_rsp      = (state_q == S_DATA) && i_mem_rvalid && own_dm_q;
  assign o_if_rvalid = (state_q == S_DATA) && i_mem_rvalid && !own_dm_q;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_dm_rvalid = dm_rsp || err_rsp;
  assign o_dm_err    = err_rsp;
  assign o_dm_rdata  = (dm_rsp && !store_q) ? load_val : '0;

  assign o_if_gnt    = if_gnt_q;
  assign o_dm_gnt    = dm_gnt_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      last_dm_q   <= 1'b0;
      own_dm_q    <= 1'b0;
      store_q     <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 3'b000;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
    end else begin
      if_gnt_q <= 1'b0;
      dm_gnt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_if_req || i_dm_req) begin
            last_dm_q <= pick_dm_d;
            own_dm_q  <= pick_dm_d;
            store_q   <= pick_dm_d && i_dm_we;
            lane_q    <= pick_dm_d ? dm_lane : 2'b00;
            size_q    <= pick_dm_d ? i_dm_size : 3'b010;
            if_gnt_q  <= !pick_dm_d;
            dm_gnt_q  <= pick_dm_d;
            if (pick_dm_d && dm_bad_d) begin
              state_q <= S_ERR;
            end else begin
              state_q     <= S_ADDR;
              mem_req_q   <= 1'b1;
              mem_we_q    <= mem_we_d;
              mem_addr_q  <= mem_addr_d;
              mem_wdata_q <= mem_wdata_d;
              mem_be_q    <= mem_be_d;
            end
          end
        end
        S_ADDR: begin
          if (i_mem_ready) begin
            state_q   <= S_DATA;
            mem_req_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (i_mem_rvalid) state_q <= S_IDLE;
        end
        S_ERR: begin
          if (!dm_gnt_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req, i_dm_we;
  logic [2:0]  i_dm_size;
  logic [31:0] i_dm_addr, i_dm_wdata;
  logic        o_dm_gnt, o_dm_rvalid, o_dm_err;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_size(i_dm_size),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_err(o_dm_err), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum logic [2:0] {M_FREE, M_ADDR, M_DATA, M_EGNT, M_ERSP} mph_t;
  mph_t        m_ph = M_FREE;
  bit          m_valid = 1'b0;
  bit          m_last_dm, m_own_dm, m_if_gnt, m_dm_gnt, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [2:0]  m_size;
  logic [1:0]  m_lane;

  function automatic bit legal(input bit we, input logic [2:0] sz, input logic [31:0] a);
    case (sz)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      3'd4:    return !we;
      3'd5:    return !we && (a[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] sz, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * lane);
    case (sz)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd4:    return {24'b0, s[7:0]};
      3'd5:    return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge i_clk) begin : model
    bit take_dm;
    m_if_gnt = 1'b0;
    m_dm_gnt = 1'b0;
    if (i_rst) begin
      m_ph = M_FREE;
      m_last_dm = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_ph)
        M_FREE: if (i_if_req || i_dm_req) begin
          take_dm = i_dm_req && !(i_if_req && m_last_dm);
          m_last_dm = take_dm;
          m_own_dm = take_dm;
          if (take_dm) begin
            m_dm_gnt = 1'b1;
            m_we = i_dm_we;
            m_size = i_dm_size;
            m_lane = i_dm_addr[1:0];
            m_addr = i_dm_addr & ~32'h3;
            m_be = 4'hF;
            m_wdata = 32'h0;
            if (i_dm_we) begin
              if (i_dm_size == 3'd0) begin
                m_be = 4'(1 << m_lane);
                m_wdata = (i_dm_wdata & 32'hFF) << (8 * m_lane);
              end else if (i_dm_size == 3'd1) begin
                m_be = 4'(3 << m_lane);
                m_wdata = (i_dm_wdata & 32'hFFFF) << (8 * m_lane);
              end else begin
                m_wdata = i_dm_wdata;
              end
            end
            m_ph = legal(i_dm_we, i_dm_size, i_dm_addr) ? M_ADDR : M_EGNT;
          end else begin
            m_if_gnt = 1'b1;
            m_we = 1'b0;
            m_size = 3'd2;
            m_lane = 2'd0;
            m_addr = i_if_addr & ~32'h3;
            m_be = 4'hF;
            m_ph = M_ADDR;
          end
        end
        M_ADDR: if (i_mem_ready) m_ph = M_DATA;
        M_DATA: if (i_mem_rvalid) m_ph = M_FREE;
        M_EGNT: m_ph = M_ERSP;
        default: m_ph = M_FREE;
      endcase
    end
  end

  always @(negedge i_clk) begin : compare
    bit exp_req, if_rv, dm_rv, dm_er;
    if (m_valid) begin
      exp_req = (m_ph == M_ADDR);
      if_rv = (m_ph == M_DATA) && i_mem_rvalid && !m_own_dm;
      dm_rv = ((m_ph == M_DATA) && i_mem_rvalid && m_own_dm) || (m_ph == M_ERSP);
      dm_er = (m_ph == M_ERSP);
      chk1("if_gnt", o_if_gnt, m_if_gnt);
      chk1("dm_gnt", o_dm_gnt, m_dm_gnt);
      chk1("mem_req", o_mem_req, exp_req);
      chk1("if_rvalid", o_if_rvalid, if_rv);
      chk1("dm_rvalid", o_dm_rvalid, dm_rv);
      chk1("dm_err", o_dm_err, dm_er);
      if (exp_req) begin
        chk32("mem_addr", o_mem_addr, m_addr);
        chk32("mem_be", 32'(o_mem_be), 32'(m_be));
        chk1("mem_we", o_mem_we, m_we);
        if (m_we) chk32("mem_wdata", o_mem_wdata, m_wdata);
      end
      if (if_rv) chk32("if_rdata", o_if_rdata, i_mem_rdata);
      if (dm_rv) chk32("dm_rdata", o_dm_rdata,
                       (dm_er || m_we) ? 32'h0 : load_val(m_size, m_lane, i_mem_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_gnt(output bit gi, output bit gd);
    gi = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_if_gnt || o_dm_gnt) begin
        gi = o_if_gnt;
        gd = o_dm_gnt;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout: got no grant within 20 cycles, required one");
  endtask

  // Called at the negedge of the first ADDR cycle; returns post-edge in IDLE.
  task automatic respond(input int gap, input logic [31:0] rd, output bit irv, output bit drv,
                         output bit der, output logic [31:0] ird, output logic [31:0] drd);
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    repeat (gap) step();
    i_mem_rvalid = 1'b1;
    i_mem_rdata = rd;
    @(negedge i_clk);
    irv = o_if_rvalid;
    drv = o_dm_rvalid;
    der = o_dm_err;
    ird = o_if_rdata;
    drd = o_dm_rdata;
    step();
    i_mem_rvalid = 1'b0;
  endtask

  task automatic set_dm(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    i_dm_req = 1'b1;
    i_dm_we = we;
    i_dm_size = sz;
    i_dm_addr = a;
    i_dm_wdata = wd;
  endtask

  logic [2:0] sz_tab [0:9];

  initial begin
    bit gi, gd, irv, drv, der;
    logic [31:0] ird, drd;
    sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    i_rst = 1'b1;
    i_if_req = 1'b0; i_if_addr = 32'h0;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_size = 3'd0; i_dm_addr = 32'h0; i_dm_wdata = 32'h0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    step();
    step();
    @(negedge i_clk);
    chk1("rst_mem_req", o_mem_req, 1'b0);
    chk1("rst_mem_we", o_mem_we, 1'b0);
    chk32("rst_mem_addr", o_mem_addr, 32'h0);
    chk32("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk32("rst_mem_be", 32'(o_mem_be), 32'h0);
    chk1("rst_gnt", o_if_gnt | o_dm_gnt, 1'b0);
    step();
    i_rst = 1'b0;

    // fetch of 0x100, response two cycles after the address phase
    i_if_req = 1'b1; i_if_addr = 32'h100;
    wait_gnt(gi, gd);
    chk1("f_if_gnt", gi, 1'b1);
    chk1("f_dm_gnt", gd, 1'b0);
    chk32("f_mem_addr", o_mem_addr, 32'h100);
    chk32("f_mem_be", 32'(o_mem_be), 32'hF);
    chk1("f_mem_we", o_mem_we, 1'b0);
    i_if_req = 1'b0;
    respond(2, 32'hDEADBEEF, irv, drv, der, ird, drd);
    chk1("f_if_rvalid", irv, 1'b1);
    chk32("f_if_rdata", ird, 32'hDEADBEEF);
    chk1("f_dm_rvalid", drv, 1'b0);

    // simultaneous requests from reset: data, fetch, data
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    set_dm(1'b0, 3'd2, 32'h80, 32'h0);
    wait_gnt(gi, gd);
    chk1("arb1_dm", gd, 1'b1);
    i_dm_req = 1'b0;
    respond(0, 32'h11111111, irv, drv, der, ird, drd);
    chk32("arb1_rdata", drd, 32'h11111111);
    wait_gnt(gi, gd);
    chk1("arb2_if", gi, 1'b1);
    i_if_req = 1'b1; i_if_addr = 32'h44;
    set_dm(1'b0, 3'd2, 32'h84, 32'h0);
    respond(0, 32'h22222222, irv, drv, der, ird, drd);
    chk1("arb2_if_rvalid", irv, 1'b1);
    wait_gnt(gi, gd);
    chk1("arb3_dm", gd, 1'b1);
    i_dm_req = 1'b0;
    respond(0, 32'h33333333, irv, drv, der, ird, drd);
    wait_gnt(gi, gd);
    chk1("arb4_if", gi, 1'b1);
    i_if_req = 1'b0;
    respond(0, 32'h44444444, irv, drv, der, ird, drd);

    // LB / LBU at 0x203
    set_dm(1'b0, 3'd0, 32'h203, 32'h0);
    wait_gnt(gi, gd);
    chk32("lb_mem_addr", o_mem_addr, 32'h200);
    chk32("lb_mem_be", 32'(o_mem_be), 32'hF);
    i_dm_req = 1'b0;
    respond(1, 32'h80FF1234, irv, drv, der, ird, drd);
    chk1("lb_rvalid", drv, 1'b1);
    chk32("lb_rdata", drd, 32'hFFFFFF80);
    set_dm(1'b0, 3'd4, 32'h203, 32'h0);
    wait_gnt(gi, gd);
    i_dm_req = 1'b0;
    respond(0, 32'h80FF1234, irv, drv, der, ird, drd);
    chk32("lbu_rdata", drd, 32'h00000080);

    // SH at 0x402
    set_dm(1'b1, 3'd1, 32'h402, 32'h0000ABCD);
    wait_gnt(gi, gd);
    chk32("sh_mem_be", 32'(o_mem_be), 32'hC);
    chk32("sh_mem_wdata", o_mem_wdata, 32'hABCD0000);
    chk1("sh_mem_we", o_mem_we, 1'b1);
    i_dm_req = 1'b0;
    respond(0, 32'h0, irv, drv, der, ird, drd);
    chk1("sh_rvalid", drv, 1'b1);
    chk1("sh_err", der, 1'b0);

    // misaligned LW at 0x405
    set_dm(1'b0, 3'd2, 32'h405, 32'h0);
    wait_gnt(gi, gd);
    chk1("lw_err_gnt", gd, 1'b1);
    chk1("lw_err_nomem", o_mem_req, 1'b0);
    chk1("lw_err_early_rv", o_dm_rvalid, 1'b0);
    i_dm_req = 1'b0;
    @(negedge i_clk);
    chk1("lw_err_rvalid", o_dm_rvalid, 1'b1);
    chk1("lw_err_flag", o_dm_err, 1'b1);
    chk32("lw_err_rdata", o_dm_rdata, 32'h0);
    chk1("lw_err_nomem2", o_mem_req, 1'b0);
    step();

    // reset during ADDR drops o_mem_req
    i_if_req = 1'b1; i_if_addr = 32'h280;
    wait_gnt(gi, gd);
    i_if_req = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk1("rst_addr_req", o_mem_req, 1'b0);

    // reset during DATA, stray rvalid afterwards, then a clean fetch
    i_if_req = 1'b1; i_if_addr = 32'h300;
    wait_gnt(gi, gd);
    i_if_req = 1'b0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555AAAA;
    @(negedge i_clk);
    chk1("stray_if_rvalid", o_if_rvalid, 1'b0);
    chk1("stray_dm_rvalid", o_dm_rvalid, 1'b0);
    step();
    i_mem_rvalid = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h500;
    wait_gnt(gi, gd);
    chk1("post_rst_gnt", gi, 1'b1);
    i_if_req = 1'b0;
    respond(1, 32'hCAFEF00D, irv, drv, der, ird, drd);
    chk32("post_rst_rdata", ird, 32'hCAFEF00D);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      if (m_if_gnt) i_if_req = 1'b0;
      if (m_dm_gnt) i_dm_req = 1'b0;
      if (!i_if_req && $urandom_range(3) == 0) begin
        i_if_req = 1'b1;
        i_if_addr = $urandom;
      end
      if (!i_dm_req && $urandom_range(3) == 0)
        set_dm(1'($urandom_range(1)), sz_tab[$urandom_range(9)], $urandom, $urandom);
      i_mem_ready = 1'($urandom_range(1));
      i_mem_rvalid = ($urandom_range(2) == 0);
      i_mem_rdata = $urandom;
      i_rst = ($urandom_range(299) == 0);
    end
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
